// File: rtl/cla_abs_serial_if.sv
// Ready/valid bundle for the nibble-serial two's-complement to sign-magnitude converter.
// The slave modport is the converter side; the master modport is the producer/consumer side.
interface cla_abs_serial_if #(
    parameter int WIDTH = 28
) ();
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_data;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_mag;
    logic             o_sign;
    logic             o_zero;

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_mag,
        output o_sign,
        output o_zero
    );

    modport master (
        output i_valid,
        output i_data,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_mag,
        input  o_sign,
        input  o_zero
    );
endinterface

// File: rtl/cla_abs_serial.sv
// Nibble-serial |x| for a two's-complement word: one 4-bit lookahead increment slice per cycle,
// result plus sign and zero flags presented on a ready/valid output held until accepted.
module cla_abs_serial #(
    parameter int WIDTH = 28
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    cla_abs_serial_if.slave      bus
);
    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    generate
        if (((WIDTH % 4) != 0) || (WIDTH < 8)) begin : g_bad_width
            $error("cla_abs_serial: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic               out_sign_q, out_sign_d;
    logic               zero_q, zero_d;

    logic               ready;
    logic               accept;
    logic               last;
    logic [3:0]         nib;
    logic [3:0]         prop;
    logic [3:0]         cin;
    logic               cout;
    logic [3:0]         res;
    logic [WIDTH-1:0]   acc_step;

    assign ready  = (state_q == IDLE) || ((state_q == DONE) && bus.i_ready);
    assign accept = bus.i_valid && ready;
    assign last   = (cnt_q == CNT_W'(NIB - 1));

    // Lookahead increment of ~d: every carry is a flat AND of the propagates, no ripple.
    always_comb begin
        nib      = data_q[3:0];
        prop     = ~nib;
        cin[0]   = carry_q;
        cin[1]   = prop[0] & carry_q;
        cin[2]   = prop[1] & prop[0] & carry_q;
        cin[3]   = prop[2] & prop[1] & prop[0] & carry_q;
        cout     = (&prop) & carry_q;
        res      = sign_q ? (prop ^ cin) : nib;
        acc_step = {res, acc_q[WIDTH-1:4]};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        sign_d     = sign_q;
        data_d     = data_q;
        acc_d      = acc_q;
        mag_d      = mag_q;
        out_sign_d = out_sign_q;
        zero_d     = zero_q;

        // A new word may be taken from IDLE or straight out of DONE as the result leaves.
        if (accept) begin
            data_d  = bus.i_data;
            sign_d  = bus.i_data[WIDTH-1];
            carry_d = 1'b1;
            cnt_d   = '0;
            acc_d   = '0;
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    data_d  = data_q >> 4;
                    acc_d   = acc_step;
                    carry_d = cout;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (last) begin
                        mag_d      = acc_step;
                        out_sign_d = sign_q;
                        zero_d     = (acc_step == '0);
                        state_d    = DONE;
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            carry_q    <= 1'b1;
            sign_q     <= 1'b0;
            data_q     <= '0;
            acc_q      <= '0;
            mag_q      <= '0;
            out_sign_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            sign_q     <= sign_d;
            data_q     <= data_d;
            acc_q      <= acc_d;
            mag_q      <= mag_d;
            out_sign_q <= out_sign_d;
            zero_q     <= zero_d;
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_valid = (state_q == DONE);
    assign bus.o_mag   = mag_q;
    assign bus.o_sign  = out_sign_q;
    assign bus.o_zero  = zero_q;
endmodule

// File: doc/cla_abs_serial.md
Name: cla_abs_serial

Overview:
- Nibble-serial two's-complement to sign-magnitude converter for the FPU mantissa path.
- Sits after the mantissa subtract stage of the FFT butterfly add/sub unit. Takes a signed difference and returns |x| plus a sign flag, which feed the normaliser and leading-zero logic.
- One 4-bit carry-lookahead increment slice is processed per cycle, so each cycle is only a 4-bit-deep carry chain.
- It is the inverse direction of the 4-bit negation slice: magnitude is recovered from a two's-complement word.

Parameters:
- WIDTH, 28, data width in bits. Must be a multiple of 4 and at least 8; other values are an elaboration error.
- NIB, WIDTH/4, derived localparam giving the number of nibble steps. Not user-settable.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  input word valid.
- o_ready  out  1  block can accept a word.
- i_data  in  WIDTH  two's-complement input.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_mag  out  WIDTH  unsigned magnitude |i_data|.
- o_sign  out  1  sign of the accepted input (1 = negative).
- o_zero  out  1  result magnitude is zero.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, nibble counter=0, carry=1.
  - o_valid=0, o_mag=0, o_sign=0, o_zero=0.
  - o_ready=1, since it is decoded from IDLE. Inputs are ignored while i_rst_n=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: o_ready=1. On i_valid&&o_ready, capture i_data into the shift register and set sign=i_data[WIDTH-1], carry=1, cnt=0, then go to RUN.
  - RUN: o_ready=0, o_valid=0. Each cycle, process nibble d=data[4*cnt+3:4*cnt]:
    - If sign=1: r = ~d + carry, computed with a 4-bit lookahead increment (p=~d, c[k+1]=p[k]&c[k]). carry_next = carry & (d==4'h0).
    - If sign=0: r = d and carry is unused.
    - Write r to o_mag[4*cnt+3:4*cnt]. This may use a shift-right accumulator; only the final value is architecturally visible.
    - cnt increments. When cnt==NIB-1, go to DONE.
  - DONE: o_valid=1. o_mag, o_sign and o_zero are stable and held while i_ready=0.
    - On i_ready=1: if i_valid=1 in the same cycle, the new word is accepted (o_ready = IDLE || (DONE && i_ready)) and the FSM goes straight to RUN. Otherwise it goes to IDLE.
- Latency: the accept edge is edge 0, and o_valid rises after edge NIB (7 cycles at default). Throughput is 1 word per NIB+1 cycles under back-to-back traffic.
- o_mag and o_sign are not updated during RUN until the step at cnt==NIB-1. Downstream must qualify them by o_valid only.
- o_zero = (o_mag==0). It is registered together with the DONE transition.
- Boundary conditions:
  - Most-negative input 1000…0: o_mag = 1000…0 (2^(WIDTH-1), representable unsigned), o_sign=1. No overflow flag.
  - Input 0: o_mag=0, o_sign=0, o_zero=1.
  - Input -1 (all ones): the carry propagates through all NIB steps, giving o_mag=1.
  - Positive input: o_mag=i_data, o_sign=0.
- Reset mid-RUN or mid-DONE: the word is dropped, all outputs go to their reset values immediately (async), and the block restarts in IDLE.
- i_data and i_valid are don't-care outside an accept cycle. i_data is sampled only on the handshake edge.
- Ready/valid protocol: o_valid never drops without i_ready. The result does not change while o_valid=1 and i_ready=0.

Test Plan:
- WIDTH=28, i_data=28'hFFFFFFF, i_ready=1 -> o_valid exactly 7 cycles after accept with o_mag=28'h0000001, o_sign=1, o_zero=0; o_ready=0 during RUN.
- i_data=28'h8000000 -> o_mag=28'h8000000, o_sign=1. Then i_data=28'h0000000 -> o_mag=0, o_sign=0, o_zero=1.
- i_data=28'h0123456 -> o_mag=28'h0123456, o_sign=0. Then i_data=28'hFEDCBAA (-0x0123456) -> o_mag=28'h0123456, o_sign=1.
- Backpressure: i_ready=0 for 5 cycles after o_valid -> o_valid, o_mag and o_sign unchanged and o_ready=0 throughout. i_ready=1 with i_valid=0 -> IDLE, o_valid=0 next cycle.
- Back-to-back: i_valid held high with inputs -16, 15, 0xFFFFF00 and i_ready=1 -> results 16/s1, 15/s0, 256/s1. Each consecutive o_valid pulse is 8 cycles apart with no lost word.
- Reset asserted on cycle 3 of RUN for input -5 -> outputs zero and o_ready=1 asynchronously. After release, a fresh input 7 yields o_mag=7 with no residue from the aborted word.
